// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset control unit.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADR   = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE_R = 4'd6,
        EXECUTE_I = 4'd7,
        ALU_WB    = 4'd8,
        BEQ       = 4'd9,
        JAL       = 4'd10,
        HALT      = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALU_OUT    = 2'b00;
    localparam logic [1:0] RES_DATA       = 2'b01;
    localparam logic [1:0] RES_ALU_RESULT = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
    localparam logic [1:0] SRC_A_RS1    = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// Memory-port handshake between the control unit and the unified memory.
interface mc_control_fsm_if;
    logic mem_req;
    logic mem_ready;
    logic adr_src;
    logic mem_write;

    modport master (output mem_req, output adr_src, output mem_write, input mem_ready);
    modport slave  (input mem_req, input adr_src, input mem_write, output mem_ready);
endinterface

// File: rtl/alu_decoder.sv
// Maps alu_op plus instruction fields to the ALU control code.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALUC_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // sub only for R-type with bit 30 set; addi ignores bit 30
                    3'b000:  alu_control = ({op5, funct7_5} == 2'b11) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  alu_control = ALUC_SLT;
                    3'b110:  alu_control = ALUC_OR;
                    3'b111:  alu_control = ALUC_AND;
                    default: alu_control = ALUC_ADD;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle Moore control FSM for the RV32I-subset datapath.
// Optional performance counters are built when MC_PERF_CNT_EN is defined.
//
// state     | meaning
// ----------+--------------------------------------------
// FETCH     | read instruction at PC, PC <= PC+4 on ready
// DECODE    | compute branch target old_pc+imm
// MEM_ADR   | rs1+imm for lw/sw
// MEM_READ  | load access, wait for ready
// MEM_WB    | write loaded data to rd
// MEM_WRITE | store access, wait for ready
// EXECUTE_R | rs1 op rs2
// EXECUTE_I | rs1 op imm
// ALU_WB    | write ALU out register to rd
// BEQ       | compare, take branch on zero
// JAL       | PC <= target, compute old_pc+4
// HALT      | illegal opcode, absorbing until reset
module mc_control_fsm
    import mc_pkg::*;
`ifdef MC_PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 zero,
    mc_control_fsm_if.master     bus,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           imm_src,
    output logic [2:0]           alu_control,
`ifdef MC_PERF_CNT_EN
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt,
`endif
    output logic                 halted
);

    state_t     state, state_nxt;
    logic       mem_req_s, mem_write_s, adr_src_s;
    logic       ir_write_s, pc_write_s, reg_write_s, halted_s;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        mem_req_s   = 1'b0;
        adr_src_s   = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        pc_write_s  = 1'b0;
        reg_write_s = 1'b0;
        halted_s    = 1'b0;
        result_src  = RES_ALU_OUT;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        alu_op      = ALU_OP_ADD;
        case (state)
            FETCH: begin
                mem_req_s  = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU_RESULT;
                if (bus.mem_ready) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                    state_nxt  = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
                case (op)
                    OP_LW, OP_SW: state_nxt = MEM_ADR;
                    OP_R:         state_nxt = EXECUTE_R;
                    OP_I:         state_nxt = EXECUTE_I;
                    OP_BEQ:       state_nxt = BEQ;
                    OP_JAL:       state_nxt = JAL;
                    default:      state_nxt = HALT;
                endcase
            end
            MEM_ADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                state_nxt = op[5] ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
                if (bus.mem_ready) state_nxt = MEM_WB;
            end
            MEM_WB: begin
                result_src  = RES_DATA;
                reg_write_s = 1'b1;
                state_nxt   = FETCH;
            end
            MEM_WRITE: begin
                mem_req_s   = 1'b1;
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
                if (bus.mem_ready) state_nxt = FETCH;
            end
            EXECUTE_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_OP_FUNCT;
                state_nxt = ALU_WB;
            end
            EXECUTE_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_OP_FUNCT;
                state_nxt = ALU_WB;
            end
            ALU_WB: begin
                reg_write_s = 1'b1;
                state_nxt   = FETCH;
            end
            BEQ: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALU_OP_SUB;
                pc_write_s = zero;
                state_nxt  = FETCH;
            end
            JAL: begin
                alu_src_a  = SRC_A_OLD_PC;
                alu_src_b  = SRC_B_FOUR;
                pc_write_s = 1'b1;
                state_nxt  = ALU_WB;
            end
            HALT: begin
                halted_s = 1'b1;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Strobes are gated by reset so an abandoned access never commits.
    assign bus.mem_req   = mem_req_s   & ~reset;
    assign bus.mem_write = mem_write_s & ~reset;
    assign bus.adr_src   = adr_src_s;
    assign ir_write      = ir_write_s  & ~reset;
    assign pc_write      = pc_write_s  & ~reset;
    assign reg_write     = reg_write_s & ~reset;
    assign halted        = halted_s    & ~reset;
    assign imm_src       = imm_src_for(op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7_5    (funct7_5),
        .alu_control (alu_control)
    );

`ifdef MC_PERF_CNT_EN
    logic retire;

    assign retire = (state == MEM_WB) || (state == ALU_WB) || (state == BEQ) ||
                    ((state == MEM_WRITE) && bus.mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (state != HALT) cycle_cnt   <= cycle_cnt + CNT_W'(1);
            if (retire)        instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
